clk_div_gen: RTL and testbench
==============================

Name: clk_div_gen

Overview:
- Parametrised multi-channel clock divider. It replaces the single fixed divide-by-100000 toggle counter used to derive the slow core clock on the FPGA prototype.
- Each channel produces a 50%-duty divided clock and a one-cycle tick enable.
- The divisor is programmable at runtime through a shadow register. New divisors are applied only at a half-period boundary, so there are no runt pulses.
- Channels start and stop glitch-free and can be phase-aligned with a sync pulse. It sits between the board clock and the core, 7-seg multiplexer and encoder debouncer.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
CNT_W, 24, width of half-period counter and divisor registers
DEFAULT_HALF, 49999, reset value of every channel's half-period count (100 MHz -> 1 kHz)
CH_W, $clog2(NUM_CH) (min 1), localparam, width of cfg_ch

Ports:
clk  in  1  board clock
rst  in  1  asynchronous active-high reset
ch_en  in  NUM_CH  per-channel run request
cfg_wr  in  1  one-cycle divisor write strobe
cfg_ch  in  CH_W  target channel of write
cfg_half  in  CNT_W  new half-period count; half-period = cfg_half+1 clk cycles
sync_req  in  1  one-cycle phase-align strobe
clk_out  out  NUM_CH  divided clocks, registered
tick  out  NUM_CH  one-cycle pulse coinciding with each clk_out 0->1
running  out  NUM_CH  channel is counting (not parked)
pending  out  NUM_CH  shadow divisor waiting to be applied

Behaviour:
- Reset (async, all channels):
  - Registers: cnt=0, clk_out=0, tick=0, running=0, pending=0, active=shadow=DEFAULT_HALF.
  - All outputs go low immediately, with no clock edge required.
- Per-channel state: PARKED (clk_out=0, cnt=0), RUN, DRAIN (ch_en=0 while clk_out=1).
- PARKED:
  - If ch_en=1, go to RUN next cycle; running=1.
  - If pending=1, active<=shadow and pending<=0 every parked cycle.
- RUN:
  - If cnt==active: cnt<=0, clk_out<=~clk_out, and tick<=1 iff clk_out goes 0->1. If pending was set before this cycle, active<=shadow and pending<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - Period = 2*(active+1) clk cycles. The first rising edge occurs active+1 cycles after entering RUN.
- ch_en drops while clk_out=0 in RUN: go to PARKED next cycle (cnt<=0, running<=0).
- ch_en drops while clk_out=1: go to DRAIN.
  - DRAIN counts normally until the falling toggle, then enters PARKED. The high phase is never truncated by disable.
  - If ch_en re-asserts during DRAIN, return to RUN seamlessly with no phase change.
- Config write (cfg_wr=1, cfg_ch<NUM_CH): shadow[cfg_ch]<=cfg_half, pending[cfg_ch]<=1.
  - A write with cfg_ch>=NUM_CH is ignored.
  - A write in the same cycle as that channel's terminal count: the old shadow is applied if pending was already set. The new value lands in shadow and pending stays 1 until the next boundary.
- cfg_half=0 is legal: clk_out toggles every cycle (clk/2) and tick fires every 2 cycles.
- sync_req:
  - Applies to all channels in RUN or DRAIN: cnt<=0, clk_out<=0, tick<=0. A pending divisor is applied.
  - Channels in DRAIN go to PARKED. Channels in RUN stay in RUN.
  - sync_req has priority over terminal count and may truncate a high phase; this is intentional for phase alignment.
  - PARKED channels are unaffected.
- Arithmetic: cnt is CNT_W-bit unsigned and never exceeds active, so there is no wrap. Compare is equality only.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The module instantiates no clock buffers. Downstream use of clk_out as a clock is the integrator's choice; tick is the preferred enable.

Test Plan:
1. Basic run: DEFAULT_HALF=3, release rst, ch_en[0]=1 at cycle 0.
   - Expected: running=1 at cycle 1; clk_out[0] rises at cycle 5 with tick=1 for exactly that cycle.
   - Expected: period 8 cycles, duty 4/4.
2. Reconfig mid-high: write cfg_half=1 to ch0 at high-phase cycle 1.
   - Expected: pending=1; current high lasts 4 cycles, then halves are 2 cycles; pending=0 after the boundary.
3. Disable while high: drop ch_en[0] at high-phase cycle 1.
   - Expected: clk_out stays high 4 cycles total, falls, running=0, no further tick.
   - Repeat with ch_en re-asserted during DRAIN: waveform is uninterrupted.
4. Sync alignment: two channels at half=3 and half=5, out of phase; pulse sync_req.
   - Expected: both clk_out=0, cnt=0 next cycle; ch0 rises after 4 cycles and ch1 after 6; ticks coincide every 24 cycles.
5. Edge cases:
   - cfg_half=0 on ch1: toggles every cycle, tick every 2 cycles.
   - cfg_ch=NUM_CH write: no state change.
   - Write on terminal-count cycle: new value applied one boundary later.
6. Async reset mid-high: assert rst between clk edges.
   - Expected: clk_out, tick, running, pending go 0 without a clock edge; after release, the channel behaves as in scenario 1 with DEFAULT_HALF.

Source files
------------

// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: 50%-duty divided clocks plus tick enables,
// with shadowed divisor updates at half-period boundaries, glitch-free start/stop and phase sync.
module clk_div_gen #(
  parameter int          NUM_CH       = 2,
  parameter int          CNT_W        = 24,
  parameter int unsigned DEFAULT_HALF = 49999,
  localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic [1:0] {PARKED, RUN, DRAIN} ch_state_e;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             running_q, running_d;
    logic             pending_q, pending_d;
    logic             apply;
    logic             wr_sel;
    logic             terminal;

    // Out-of-range channel numbers never match any channel, so such writes are dropped.
    assign wr_sel   = cfg_wr && (32'(cfg_ch) == i);
    assign terminal = (cnt_q == active_q);

    always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      apply     = 1'b0;

      case (state_q)
        PARKED: begin
          apply = pending_q;
          if (ch_en[i]) state_d = RUN;
        end
        RUN, DRAIN: begin
          if (sync_req) begin
            // Phase alignment wins over terminal count and may cut a high phase short.
            cnt_d   = '0;
            clk_d   = 1'b0;
            apply   = pending_q;
            state_d = (state_q == RUN && ch_en[i]) ? RUN : PARKED;
          end else if (state_q == RUN && !ch_en[i] && !clk_q) begin
            cnt_d   = '0;
            state_d = PARKED;
          end else if (terminal) begin
            cnt_d   = '0;
            clk_d   = !clk_q;
            tick_d  = !clk_q;
            apply   = pending_q;
            state_d = ch_en[i] ? RUN : PARKED;
          end else begin
            // Disabled while high: keep counting so the high phase is never truncated.
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ch_en[i] ? RUN : DRAIN;
          end
        end
        default: state_d = PARKED;
      endcase

      if (apply) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
      // A write landing on a boundary is held for the next one.
      if (wr_sel) begin
        shadow_d  = cfg_half;
        pending_d = 1'b1;
      end
      running_d = (state_d != PARKED);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= PARKED;
        cnt_q     <= '0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
        running_q <= 1'b0;
        pending_q <= 1'b0;
        active_q  <= CNT_W'(DEFAULT_HALF);
        shadow_q  <= CNT_W'(DEFAULT_HALF);
      end else begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
        running_q <= running_d;
        pending_q <= pending_d;
        active_q  <= active_d;
        shadow_q  <= shadow_d;
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign running[i] = running_q;
    assign pending[i] = pending_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Self-checking bench for clk_div_gen: table-driven basic run, hand-written corner
// sequences and a randomized phase against a countdown-based reference model.
module tb_clk_div_gen;

  localparam int N    = 3;
  localparam int CW   = 8;
  localparam int DEFH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  ch_en;
  logic          cfg_wr;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_half;
  logic          sync_req;
  logic [N-1:0]  clk_out, tick, running, pending;

  clk_div_gen #(.NUM_CH(N), .CNT_W(CW), .DEFAULT_HALF(DEFH)) dut (
    .clk(clk), .rst(rst), .ch_en(ch_en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .sync_req(sync_req), .clk_out(clk_out), .tick(tick),
    .running(running), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel counts down the cycles left in its current half period.
  bit m_on[N], m_level[N], m_tick[N], m_pend[N], m_drain[N];
  int m_left[N], m_act[N], m_shad[N];

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_on[c] = 0; m_level[c] = 0; m_tick[c] = 0; m_pend[c] = 0; m_drain[c] = 0;
      m_left[c] = DEFH; m_act[c] = DEFH; m_shad[c] = DEFH;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      bit en;
      bit apply;
      bit restart;
      en = ch_en[c];
      apply = 0;
      restart = 1;
      m_tick[c] = 0;
      if (!m_on[c]) begin
        apply = m_pend[c];
        if (en) begin m_on[c] = 1; m_drain[c] = 0; end
      end else if (sync_req) begin
        m_level[c] = 0;
        apply = m_pend[c];
        m_on[c] = en && !m_drain[c];
        m_drain[c] = 0;
      end else if (!m_level[c] && !en) begin
        m_on[c] = 0;
      end else if (m_left[c] == 0) begin
        m_level[c] = !m_level[c];
        m_tick[c] = m_level[c];
        apply = m_pend[c];
        m_on[c] = en;
        m_drain[c] = 0;
      end else begin
        m_left[c]--;
        m_drain[c] = !en;
        restart = 0;
      end
      if (apply) begin m_act[c] = m_shad[c]; m_pend[c] = 0; end
      if (restart) m_left[c] = m_act[c];
      if (cfg_wr && int'(cfg_ch) == c) begin m_shad[c] = int'(cfg_half); m_pend[c] = 1; end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] e_clk, e_tick, e_run, e_pend;
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      e_clk[c] = m_level[c]; e_tick[c] = m_tick[c]; e_run[c] = m_on[c]; e_pend[c] = m_pend[c];
    end
    check("model", {clk_out, tick, running, pending}, {e_clk, e_tick, e_run, e_pend});
    cfg_wr = 1'b0;
    sync_req = 1'b0;
  endtask

  task automatic wait_level(input int ch, input logic lvl, input int budget, output int n);
    n = 0;
    while (clk_out[ch] !== lvl && n < budget) begin
      cycle();
      n++;
    end
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [CW-1:0] half);
    cfg_wr = 1'b1; cfg_ch = ch; cfg_half = half;
  endtask

  typedef struct {
    logic en;
    logic exp_clk;
    logic exp_tick;
    logic exp_run;
    logic exp_pend;
  } vec_t;
  vec_t tbl[13];

  task automatic run_table();
    for (int i = 0; i < 13; i++) begin
      ch_en = {2'b00, tbl[i].en};
      cycle();
      check($sformatf("table_row%0d", i), {clk_out[0], tick[0], running[0], pending[0]},
            {tbl[i].exp_clk, tbl[i].exp_tick, tbl[i].exp_run, tbl[i].exp_pend});
    end
  endtask

  initial begin
    int n;
    int t0, t1, first0, first1, tog;
    logic prev;

    // Basic run with DEFAULT_HALF=3: rises 4 cycles after entering RUN, period 8.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; ch_en = '0; cfg_wr = 1'b0; cfg_ch = '0; cfg_half = '0; sync_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_outputs", {clk_out, tick, running, pending}, 0);
    rst = 1'b0;

    run_table();

    // Reconfigure during high phase cycle 1.
    write_cfg(2'd0, 8'd1);
    cycle();
    check("reconf_pending_set", {clk_out[0], pending[0]}, 2'b11);
    wait_level(0, 1'b0, 40, n);
    check("reconf_rest_of_high", n, 3);
    check("reconf_pending_clear", pending[0], 0);
    wait_level(0, 1'b1, 40, n);
    check("reconf_new_low", n, 2);
    wait_level(0, 1'b0, 40, n);
    check("reconf_new_high", n, 2);

    // Async reset in the middle of a high phase.
    wait_level(0, 1'b1, 40, n);
    #2 rst = 1'b1;
    model_reset();
    #1 check("async_reset", {clk_out, tick, running, pending}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_table();

    // Disable during high phase cycle 1: high phase still lasts 4 cycles.
    ch_en = 3'b000;
    cycle();
    check("drain_running", {clk_out[0], running[0]}, 2'b11);
    wait_level(0, 1'b0, 40, n);
    check("drain_fall", n, 3);
    check("drain_parked", running[0], 0);
    t0 = 0;
    for (int i = 0; i < 12; i++) begin cycle(); t0 += int'(tick[0]); end
    check("drain_no_tick", t0, 0);

    // Re-enable during DRAIN: waveform carries on unchanged.
    ch_en = 3'b001;
    wait_level(0, 1'b1, 40, n);
    check("restart_rise", n, 5);
    ch_en = 3'b000;
    cycle();
    ch_en = 3'b001;
    cycle();
    wait_level(0, 1'b0, 40, n);
    check("reenable_fall", n, 2);
    check("reenable_running", running[0], 1);
    wait_level(0, 1'b1, 40, n);
    check("reenable_low", n, 4);

    // Sync two channels with half=3 and half=5.
    write_cfg(2'd1, 8'd5);
    cycle();
    repeat (3) cycle();
    ch_en = 3'b011;
    repeat (7) cycle();
    sync_req = 1'b1;
    cycle();
    check("sync_state", {clk_out[1:0], tick[1:0], running[1:0]}, 6'b000011);
    t0 = 0; t1 = 0; first0 = 0; first1 = 0;
    for (int k = 1; k <= 48; k++) begin
      cycle();
      if (tick[0]) begin t0++; if (first0 == 0) first0 = k; end
      if (tick[1]) begin t1++; if (first1 == 0) first1 = k; end
    end
    check("sync_first_rise_ch0", first0, 4);
    check("sync_first_rise_ch1", first1, 6);
    check("sync_ticks_ch0", t0, 6);
    check("sync_ticks_ch1", t1, 4);

    // cfg_half=0 gives clk/2.
    write_cfg(2'd1, 8'd0);
    cycle();
    repeat (12) cycle();
    prev = clk_out[1]; tog = 0; t1 = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (clk_out[1] !== prev) tog++;
      prev = clk_out[1];
      t1 += int'(tick[1]);
    end
    check("half0_toggles", tog, 8);
    check("half0_ticks", t1, 4);

    // Write to a nonexistent channel is ignored.
    write_cfg(2'd3, 8'd9);
    cycle();
    check("bad_ch_write", pending, 0);

    // Write on the terminal-count cycle: old shadow applied now, new one a boundary later.
    wait_level(0, 1'b0, 40, n);
    wait_level(0, 1'b1, 40, n);
    write_cfg(2'd0, 8'd2);
    cycle();
    cycle();
    cycle();
    write_cfg(2'd0, 8'd1);
    cycle();
    check("tc_write_boundary", {clk_out[0], pending[0]}, 2'b01);
    wait_level(0, 1'b1, 40, n);
    check("tc_write_old_shadow", n, 3);
    check("tc_write_applied", pending[0], 0);
    wait_level(0, 1'b0, 40, n);
    check("tc_write_new_shadow", n, 2);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        int b;
        b = int'($urandom_range(0, N - 1));
        ch_en[b] = ~ch_en[b];
      end
      cfg_wr   = ($urandom_range(0, 7) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_half = 8'($urandom_range(0, 5));
      sync_req = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
